// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, mstatus fields, cause codes and sequencer types
// Exports: CSR_* addresses, MSTATUS_* bit positions, CAUSE_* codes,
//          seq_state_e, acc_e, mstatus_trap_lo/mstatus_mret_lo helpers.
package csr_pkg;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MEIE       = 11;
   localparam int MIE_MTIE       = 7;
   localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
   localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
   localparam logic [4:0] CAUSE_IRQ_EXT   = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
   typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, M_STAT, M_PC} seq_state_e;
   typedef enum logic [1:0] {ACC_NONE, ACC_TRAP, ACC_MRET, ACC_PIPE} acc_e;
   // Only the low 13 bits of mstatus are touched on trap entry/exit.
   function automatic logic [12:0] mstatus_trap_lo(input logic [12:0] s);
      logic [12:0] r;
      r = s;
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE] = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction
   function automatic logic [12:0] mstatus_mret_lo(input logic [12:0] s);
      logic [12:0] r;
      r = s;
      r[MSTATUS_MIE] = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: IDLE request arbiter, exception > interrupt > mret > pipeline write
// Inputs : exc_valid, exc_code, irq_ext_take, irq_timer_take (already enable-qualified),
//          mret_valid, pipe_csr_we
// Outputs: acc (accept type), intr (interrupt flag for mcause), code (cause code to latch)
module trap_prio_enc
   import csr_pkg::*;
(
   input  logic       exc_valid,
   input  logic [4:0] exc_code,
   input  logic       irq_ext_take,
   input  logic       irq_timer_take,
   input  logic       mret_valid,
   input  logic       pipe_csr_we,
   output acc_e       acc,
   output logic       intr,
   output logic [4:0] code
);
   logic irq_any;
   always_comb begin
      irq_any = irq_ext_take | irq_timer_take;
      acc = (exc_valid | irq_any) ? ACC_TRAP : mret_valid ? ACC_MRET : pipe_csr_we ? ACC_PIPE : ACC_NONE;
      intr = !exc_valid && irq_any;
      code = exc_valid ? exc_code : irq_ext_take ? CAUSE_IRQ_EXT : irq_timer_take ? CAUSE_IRQ_TIMER : 5'd0;
   end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap/MRET sequencer owning the CSR write port
// Inputs : exc_* (exception), mret_valid, irq_* (interrupts), pipe_csr_* (pipeline CSR write),
//          csr_data_r (combinational CSR read data)
// Outputs: req_ack, pipe_csr_stall, csr_we/csr_addr_w/csr_data_w, csr_addr_r, flush,
//          redirect_valid/redirect_pc, busy
// Build option: TRAP_SEQ_IRQ_EN enables interrupts and vectored mtvec.
module trap_sequencer
   import csr_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exc_valid,
   input  logic [4:0]        exc_code,
   input  logic [XLEN-1:0]   exc_pc,
   input  logic [XLEN-1:0]   exc_tval,
   input  logic              mret_valid,
   input  logic              irq_ext,
   input  logic              irq_timer,
   input  logic [XLEN-1:0]   irq_pc,
   output logic              req_ack,
   input  logic              pipe_csr_we,
   input  logic [CSR_AW-1:0] pipe_csr_addr,
   input  logic [XLEN-1:0]   pipe_csr_data,
   output logic              pipe_csr_stall,
   output logic              csr_we,
   output logic [CSR_AW-1:0] csr_addr_w,
   output logic [XLEN-1:0]   csr_data_w,
   output logic [CSR_AW-1:0] csr_addr_r,
   input  logic [XLEN-1:0]   csr_data_r,
   output logic              flush,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              busy
);
   seq_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, tval_q, tval_d;
   logic [4:0]      code_q, code_d;
   logic            intr_q, intr_d;
   logic            irq_ext_take, irq_timer_take;
   logic [XLEN-1:0] vec_off;
   acc_e            acc;
   logic            acc_intr;
   logic [4:0]      acc_code;

`ifdef TRAP_SEQ_IRQ_EN
   // Snapshot of mstatus.MIE and mie enables, tracked from every write through our own port.
   logic snap_mie_q, snap_mie_d, snap_meie_q, snap_meie_d, snap_mtie_q, snap_mtie_d;
   always_comb begin
      snap_mie_d = snap_mie_q;
      snap_meie_d = snap_meie_q;
      snap_mtie_d = snap_mtie_q;
      if (csr_we && csr_addr_w == CSR_AW'(CSR_MSTATUS)) snap_mie_d = csr_data_w[MSTATUS_MIE];
      if (csr_we && csr_addr_w == CSR_AW'(CSR_MIE)) begin
         snap_meie_d = csr_data_w[MIE_MEIE];
         snap_mtie_d = csr_data_w[MIE_MTIE];
      end
      irq_ext_take = snap_mie_q & snap_meie_q & irq_ext;
      irq_timer_take = snap_mie_q & snap_mtie_q & irq_timer;
      vec_off = (csr_data_r[1:0] == 2'b01) ? XLEN'({code_q, 2'b00}) : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_mie_q <= 1'b0;
         snap_meie_q <= 1'b0;
         snap_mtie_q <= 1'b0;
      end else begin
         snap_mie_q <= snap_mie_d;
         snap_meie_q <= snap_meie_d;
         snap_mtie_q <= snap_mtie_d;
      end
   end
`else
   logic unused_irq;
   assign unused_irq = irq_ext ^ irq_timer;
   assign irq_ext_take = 1'b0;
   assign irq_timer_take = 1'b0;
   assign vec_off = '0;
`endif

   trap_prio_enc u_prio (
      .exc_valid      (exc_valid),
      .exc_code       (exc_code),
      .irq_ext_take   (irq_ext_take),
      .irq_timer_take (irq_timer_take),
      .mret_valid     (mret_valid),
      .pipe_csr_we    (pipe_csr_we),
      .acc            (acc),
      .intr           (acc_intr),
      .code           (acc_code)
   );

   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      tval_d = tval_q;
      code_d = code_q;
      intr_d = intr_q;
      busy = (state_q != IDLE);
      pipe_csr_stall = busy & pipe_csr_we;
      req_ack = 1'b0;
      csr_we = 1'b0;
      csr_addr_w = '0;
      csr_data_w = '0;
      csr_addr_r = '0;
      flush = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      case (state_q)
         IDLE: begin
            // Outputs stay quiet while reset is asserted, even with pipeline traffic present.
            if (!rst && (acc == ACC_TRAP || acc == ACC_MRET)) begin
               req_ack = 1'b1;
               pc_d = acc_intr ? irq_pc : exc_pc;
               tval_d = (acc == ACC_TRAP && !acc_intr) ? exc_tval : '0;
               code_d = acc_code;
               intr_d = acc_intr;
               state_d = (acc == ACC_TRAP) ? T_EPC : M_STAT;
            end else if (!rst) begin
               csr_we = pipe_csr_we;
               csr_addr_w = pipe_csr_addr;
               csr_data_w = pipe_csr_data;
            end
         end
         T_EPC: begin
            csr_we = 1'b1;
            csr_addr_w = CSR_AW'(CSR_MEPC);
            csr_data_w = pc_q;
            flush = 1'b1;
            state_d = T_CAUSE;
         end
         T_CAUSE: begin
            csr_we = 1'b1;
            csr_addr_w = CSR_AW'(CSR_MCAUSE);
            csr_data_w = {intr_q, {(XLEN-6){1'b0}}, code_q};
            state_d = T_TVAL;
         end
         T_TVAL: begin
            csr_we = 1'b1;
            csr_addr_w = CSR_AW'(CSR_MTVAL);
            csr_data_w = tval_q;
            state_d = T_STAT;
         end
         T_STAT: begin
            csr_addr_r = CSR_AW'(CSR_MSTATUS);
            csr_we = 1'b1;
            csr_addr_w = CSR_AW'(CSR_MSTATUS);
            csr_data_w = {csr_data_r[XLEN-1:13], mstatus_trap_lo(csr_data_r[12:0])};
            state_d = T_VEC;
         end
         T_VEC: begin
            csr_addr_r = CSR_AW'(CSR_MTVEC);
            redirect_valid = 1'b1;
            redirect_pc = {csr_data_r[XLEN-1:2], 2'b00} + vec_off;
            state_d = IDLE;
         end
         M_STAT: begin
            csr_addr_r = CSR_AW'(CSR_MSTATUS);
            csr_we = 1'b1;
            csr_addr_w = CSR_AW'(CSR_MSTATUS);
            csr_data_w = {csr_data_r[XLEN-1:13], mstatus_mret_lo(csr_data_r[12:0])};
            flush = 1'b1;
            state_d = M_PC;
         end
         M_PC: begin
            csr_addr_r = CSR_AW'(CSR_MEPC);
            redirect_valid = 1'b1;
            redirect_pc = {csr_data_r[XLEN-1:2], 2'b00};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q <= '0;
         tval_q <= '0;
         code_q <= '0;
         intr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         tval_q <= tval_d;
         code_q <= code_d;
         intr_q <= intr_d;
      end
   end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench for trap_sequencer with a behavioural CSR file
module tb_trap_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid, mret_valid, irq_ext, irq_timer;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc, exc_tval, irq_pc;
   logic        req_ack, pipe_csr_we, pipe_csr_stall, csr_we, flush, redirect_valid, busy;
   logic [11:0] pipe_csr_addr, csr_addr_w, csr_addr_r;
   logic [31:0] pipe_csr_data, csr_data_w, csr_data_r, redirect_pc;
   logic [31:0] mem [0:4095];
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int n;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;
   ev_t wq[$];
   ev_t rq[$];

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32), .CSR_AW(12)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_pc(irq_pc),
      .req_ack(req_ack),
      .pipe_csr_we(pipe_csr_we), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_data(pipe_csr_data),
      .pipe_csr_stall(pipe_csr_stall),
      .csr_we(csr_we), .csr_addr_w(csr_addr_w), .csr_data_w(csr_data_w),
      .csr_addr_r(csr_addr_r), .csr_data_r(csr_data_r),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   assign csr_data_r = mem[csr_addr_r];
   always @(posedge clk) if (csr_we) mem[csr_addr_w] <= csr_data_w;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (csr_we) begin
         if (wq.size() == 0) chk("unexp_we", 32'(csr_we), 32'd0);
         else begin
            e = wq.pop_front();
            chk("we_addr", 32'(csr_addr_w), 32'(e.addr));
            chk("we_data", csr_data_w, e.data);
            chk("we_cyc", cyc, e.cyc);
         end
      end
      if (redirect_valid) begin
         if (rq.size() == 0) chk("unexp_redirect", 32'(redirect_valid), 32'd0);
         else begin
            e = rq.pop_front();
            chk("redir_pc", redirect_pc, e.data);
            chk("redir_cyc", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at(input int c);
      while (cyc < c) tick();
      @(negedge clk);
   endtask

   task automatic exp_w(input logic [11:0] a, input logic [31:0] d, input int c);
      wq.push_back('{a, d, c});
   endtask

   task automatic exp_r(input logic [31:0] pc, input int c);
      rq.push_back('{12'h0, pc, c});
   endtask

   task automatic trap_expect(input int c, input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] tval, input logic [31:0] mst, input logic [31:0] tgt);
      exp_w(12'h341, pc, c + 1);
      exp_w(12'h342, cause, c + 2);
      exp_w(12'h343, tval, c + 3);
      exp_w(12'h300, mst, c + 4);
      exp_r(tgt, c + 5);
   endtask

   task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
      pipe_csr_we = 1'b1;
      pipe_csr_addr = a;
      pipe_csr_data = d;
      exp_w(a, d, cyc);
      @(negedge clk);
      chk("pw_stall", 32'(pipe_csr_stall), 32'd0);
      chk("pw_ack", 32'(req_ack), 32'd0);
      tick();
      pipe_csr_we = 1'b0;
   endtask

   task automatic drained(input string tag);
      chk(tag, wq.size() + rq.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      exc_valid = 1'b1; exc_code = 5'd11; exc_pc = 32'h0; exc_tval = 32'h0;
      mret_valid = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_pc = 32'h0;
      pipe_csr_we = 1'b1; pipe_csr_addr = 12'h340; pipe_csr_data = 32'hFFFF;
      #2;
      chk("rst_we", 32'(csr_we), 32'd0);
      chk("rst_addr_w", 32'(csr_addr_w), 32'd0);
      chk("rst_data_w", csr_data_w, 32'd0);
      chk("rst_ack", 32'(req_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_redir", 32'(redirect_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      exc_valid = 1'b0; pipe_csr_we = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Exception entry: ecall, direct mtvec.
      pipe_wr(12'h305, 32'h200);
      pipe_wr(12'h300, 32'h8);
      exc_valid = 1'b1; exc_code = 5'd11; exc_pc = 32'h100; exc_tval = 32'h0;
      n = cyc;
      trap_expect(n, 32'h100, 32'hB, 32'h0, 32'h1880, 32'h200);
      @(negedge clk);
      chk("t_ack", 32'(req_ack), 32'd1);
      tick();
      exc_valid = 1'b0;
      at(n + 1);
      chk("t_flush", 32'(flush), 32'd1);
      chk("t_busy1", 32'(busy), 32'd1);
      at(n + 5);
      chk("t_busy5", 32'(busy), 32'd1);
      at(n + 6);
      chk("t_idle", 32'(busy), 32'd0);
      drained("t_drained");
      tick();

      // MRET.
      pipe_wr(12'h341, 32'h104);
      mret_valid = 1'b1;
      n = cyc;
      exp_w(12'h300, 32'h1888, n + 1);
      exp_r(32'h104, n + 2);
      @(negedge clk);
      chk("m_ack", 32'(req_ack), 32'd1);
      tick();
      mret_valid = 1'b0;
      at(n + 1);
      chk("m_flush", 32'(flush), 32'd1);
      at(n + 3);
      chk("m_idle", 32'(busy), 32'd0);
      drained("m_drained");
      tick();

      // Exception, MRET and pipeline write collide.
      pipe_wr(12'h300, 32'h8);
      exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h200; exc_tval = 32'hDEAD;
      mret_valid = 1'b1;
      pipe_csr_we = 1'b1; pipe_csr_addr = 12'h340; pipe_csr_data = 32'h77;
      n = cyc;
      trap_expect(n, 32'h200, 32'h2, 32'hDEAD, 32'h1880, 32'h200);
      exp_w(12'h300, 32'h1888, n + 7);
      exp_r(32'h200, n + 8);
      @(negedge clk);
      chk("c_ack", 32'(req_ack), 32'd1);
      chk("c_pipe_dropped", 32'(csr_we), 32'd0);
      tick();
      exc_valid = 1'b0; pipe_csr_we = 1'b0;
      at(n + 5);
      chk("c_mret_held", 32'(req_ack), 32'd0);
      at(n + 6);
      chk("c_mret_ack", 32'(req_ack), 32'd1);
      tick();
      mret_valid = 1'b0;
      at(n + 9);
      drained("c_drained");
      tick();

      // Pipeline write during a trap is stalled, then issued in IDLE.
      exc_valid = 1'b1; exc_code = 5'd11; exc_pc = 32'h300; exc_tval = 32'h5;
      n = cyc;
      trap_expect(n, 32'h300, 32'hB, 32'h5, 32'h1880, 32'h200);
      @(negedge clk);
      chk("s_ack", 32'(req_ack), 32'd1);
      tick();
      exc_valid = 1'b0;
      tick();
      pipe_csr_we = 1'b1; pipe_csr_addr = 12'h340; pipe_csr_data = 32'h55;
      exp_w(12'h340, 32'h55, n + 6);
      @(negedge clk);
      chk("s_stall2", 32'(pipe_csr_stall), 32'd1);
      at(n + 5);
      chk("s_stall5", 32'(pipe_csr_stall), 32'd1);
      at(n + 6);
      chk("s_stall6", 32'(pipe_csr_stall), 32'd0);
      tick();
      pipe_csr_we = 1'b0;
      at(n + 8);
      drained("s_drained");
      tick();

      // Reset in T_TVAL abandons the sequence with no redirect.
      exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h400; exc_tval = 32'h9;
      n = cyc;
      exp_w(12'h341, 32'h400, n + 1);
      exp_w(12'h342, 32'h2, n + 2);
      @(negedge clk);
      chk("r_ack", 32'(req_ack), 32'd1);
      tick();
      exc_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_we", 32'(csr_we), 32'd0);
      chk("r_redir", 32'(redirect_valid), 32'd0);
      chk("r_flush", 32'(flush), 32'd0);
      tick();
      rst = 1'b0;
      at(n + 12);
      chk("r_busy_after", 32'(busy), 32'd0);
      chk("r_mepc_kept", mem[12'h341], 32'h400);
      chk("r_mtval_old", mem[12'h343], 32'h5);
      drained("r_drained");
      tick();

`ifdef TRAP_SEQ_IRQ_EN
      // External interrupt beats timer, vectored mtvec.
      pipe_wr(12'h305, 32'h301);
      pipe_wr(12'h304, 32'h880);
      pipe_wr(12'h300, 32'h8);
      irq_ext = 1'b1; irq_timer = 1'b1; irq_pc = 32'h500;
      n = cyc;
      trap_expect(n, 32'h500, 32'h8000000B, 32'h0, 32'h1880, 32'h32C);
      @(negedge clk);
      chk("i_ack", 32'(req_ack), 32'd1);
      tick();
      irq_ext = 1'b0; irq_timer = 1'b0;
      at(n + 7);
      chk("i_idle", 32'(busy), 32'd0);
      drained("i_drained");
`else
      // Interrupt lines have no effect in the default build.
      pipe_wr(12'h304, 32'h880);
      pipe_wr(12'h300, 32'h8);
      irq_ext = 1'b1; irq_timer = 1'b1; irq_pc = 32'h500;
      @(negedge clk);
      chk("i_no_ack", 32'(req_ack), 32'd0);
      tick();
      @(negedge clk);
      chk("i_no_busy", 32'(busy), 32'd0);
      irq_ext = 1'b0; irq_timer = 1'b0;
      tick();
      drained("i_drained");
`endif
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller; sole owner of the CSR file's single write port.
- Arbitrates between pipeline CSR-instruction writes and its own multi-cycle trap and MRET update sequences.
- Trap sequence: writes mepc, mcause, mtval, mstatus, then issues the mtvec redirect.
- MRET sequence: restores mstatus, then redirects to mepc.
- Sits between the execute-stage trap detection logic and the CSR register file; drives the fetch redirect and the pipeline flush.

Parameters:
- XLEN, 32, data/PC width
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock domain, asynchronous assert, active-high
- exc_valid  in  1  synchronous exception request
- exc_code  in  5  exception cause code
- exc_pc  in  XLEN  faulting instruction PC
- exc_tval  in  XLEN  trap value
- mret_valid  in  1  MRET retiring
- irq_ext  in  1  external interrupt level (IRQ_EN only)
- irq_timer  in  1  timer interrupt level (IRQ_EN only)
- irq_pc  in  XLEN  PC to resume after an interrupt
- req_ack  out  1  request accepted (1-cycle pulse)
- pipe_csr_we  in  1  pipeline CSR write
- pipe_csr_addr  in  CSR_AW  pipeline CSR address
- pipe_csr_data  in  XLEN  pipeline CSR data
- pipe_csr_stall  out  1  pipeline write refused this cycle
- csr_we  out  1  to CSR file
- csr_addr_w  out  CSR_AW  to CSR file
- csr_data_w  out  XLEN  to CSR file
- csr_addr_r  out  CSR_AW  CSR file read address
- csr_data_r  in  XLEN  CSR file combinational read data
- flush  out  1  pipeline flush pulse
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  XLEN  fetch target
- busy  out  1  sequence in progress

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, M_STAT, M_PC.
- All outputs are decoded from state and the latched registers, except the redirect_pc/mstatus read-modify path through csr_data_r.
- Reset values: state IDLE; latched pc/cause/tval = 0; every output 0.
- Reset asserted mid-sequence: return to IDLE immediately; no redirect; partially written CSRs stay as they are.
- IDLE priority: exc_valid > interrupt (IRQ_EN) > mret_valid > pipeline write.
- On accepting a trap or MRET:
  - req_ack = 1 that cycle.
  - Latch pc, cause and tval.
  - Any same-cycle pipe_csr_we is dropped; that instruction is flushed.
- In IDLE with no request: csr_we/csr_addr_w/csr_data_w pass pipe_csr_* through combinationally; pipe_csr_stall = 0.
- In any non-IDLE state: busy = 1; pipe_csr_stall = pipe_csr_we; CSR port driven by the sequencer.
- Trap path, one state per cycle:
  - T_EPC: write 0x341 with latched pc; flush = 1.
  - T_CAUSE: write 0x342 with {intr, 26'b0, code[4:0]}, intr = 0 for exceptions.
  - T_TVAL: write 0x343 with latched tval (0 for interrupts).
  - T_STAT: read 0x300; write 0x300 with MPIE(7) = MIE(3), MIE = 0, MPP(12:11) = 2'b11, other bits unchanged.
  - T_VEC: read 0x305; redirect_valid = 1; redirect_pc = {mtvec[31:2], 2'b00}; next state IDLE.
- Trap latency: accept at cycle 0, redirect at cycle 5; busy high cycles 1-5.
- MRET path:
  - M_STAT: read 0x300; write 0x300 with MIE = MPIE, MPIE = 1; flush = 1.
  - M_PC: read 0x341; redirect_valid = 1; redirect_pc = {mepc[31:2], 2'b00}; next state IDLE.
- MRET latency: redirect at cycle 2.
- Requests arriving while busy: req_ack stays 0. Requesters hold the request; it is re-arbitrated in IDLE on the cycle after redirect.
- Back-to-back: a request held during T_VEC or M_PC is accepted on the next cycle (IDLE).

Optional Feature:
- Macro TRAP_SEQ_IRQ_EN.
- Defined:
  - In IDLE, an interrupt is taken when mstatus.MIE (read 0x300) = 1 and mie bit 11 (ext) or bit 7 (timer) is set with the matching irq_* input high; mie is sampled via an extra read cycle only inside the sequence, so the IDLE check uses the mstatus/mie snapshot registered on every csr_we to those addresses.
  - Ext beats timer; latched pc = irq_pc.
  - mcause = {1'b1, 26'b0, 11 or 7}.
  - If mtvec[1:0] == 2'b01, redirect_pc = {mtvec[31:2], 2'b00} + 4*cause.
- Undefined: irq_* ignored; only direct mode is used; synthesis removes the snapshot registers.

Decomposition:
- Shared package (csr_pkg):
  - CSR address constants (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
  - Cause codes (ECALL_M 11, ILLEGAL 2, IRQ_EXT 11, IRQ_TIMER 7).
  - State enum.
- Sub-module trap_prio_enc: combinational request arbiter that yields the accept type and the latched cause.

Test Plan:
- exc_valid, code = 11, pc = 0x100, mtvec = 0x200, mstatus = 0x8 -> writes mepc 0x100, mcause 0xB, mtval 0, mstatus 0x1880 on cycles 1-4; redirect 0x200 on cycle 5.
- mret_valid, mepc = 0x104, mstatus = 0x1880 -> mstatus 0x1888 at cycle 1; redirect 0x104 at cycle 2.
- exc_valid + mret_valid + pipe_csr_we in the same cycle -> exception taken, pipe write not issued, mret held and acked after redirect.
- pipe_csr_we to 0x340 during T_CAUSE -> pipe_csr_stall = 1 and no write; the write passes through after returning to IDLE.
- rst pulsed during T_TVAL -> outputs 0, state IDLE; redirect_valid never asserted.
- TRAP_SEQ_IRQ_EN, MIE = 1, mie = 0x800, irq_ext = 1, mtvec = 0x301 -> mcause 0x8000000B; redirect 0x32C.
